// File: rtl/frame_dump_trig.sv
// Frame-count based dump trigger: counts vs falling edges and opens per-channel
// capture windows (single-shot, periodic or open-ended) at programmed frame numbers.
module frame_dump_trig #(
  parameter int CNTW = 32,
  parameter int CH   = 4,
  parameter int LENW = 16,
  localparam int CHW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            vs,
  input  logic            cfg_we,
  input  logic [CHW-1:0]  cfg_ch,
  input  logic [CNTW-1:0] cfg_start,
  input  logic [LENW-1:0] cfg_len,
  input  logic [LENW-1:0] cfg_period,
  input  logic [1:0]      cfg_mode,
  input  logic            cfg_abort,
  output logic [CNTW-1:0] frame_cnt,
  output logic            frame_tick,
  output logic [CH-1:0]   dump_on,
  output logic [CH-1:0]   dump_start,
  output logic [CH-1:0]   dump_stop,
  output logic            busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_DONE   = 2'd3
  } ch_state_e;

  localparam logic [1:0] MODE_SINGLE   = 2'd0;
  localparam logic [1:0] MODE_PERIODIC = 2'd1;
  localparam logic [1:0] MODE_OPEN     = 2'd2;

  logic            vs_d_r;
  logic            vs_vld_r;
  logic            frame_tick_r;
  logic [CNTW-1:0] frame_cnt_r;

  ch_state_e       state_r [CH];
  ch_state_e       state_s [CH];
  logic [CNTW-1:0] start_r [CH];
  logic [CNTW-1:0] start_s [CH];
  logic [LENW-1:0] rem_r   [CH];
  logic [LENW-1:0] rem_s   [CH];
  logic [LENW-1:0] len_r   [CH];
  logic [LENW-1:0] len_s   [CH];
  logic [LENW-1:0] per_r   [CH];
  logic [LENW-1:0] per_s   [CH];
  logic [LENW-1:0] step_s  [CH];
  logic [1:0]      mode_r  [CH];
  logic [1:0]      mode_s  [CH];

  logic [CH-1:0]   wr_sel_s;
  logic [CH-1:0]   ab_sel_s;
  logic [CH-1:0]   on_s;
  logic [CH-1:0]   start_pls_s;
  logic [CH-1:0]   stop_pls_s;
  logic            busy_s;
  logic [CH-1:0]   on_r;
  logic [CH-1:0]   start_pls_r;
  logic [CH-1:0]   stop_pls_r;
  logic            busy_r;

  // vs edge detector and frame counter; vs_vld_r suppresses a tick from a vs already low at reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d_r       <= 1'b1;
      vs_vld_r     <= 1'b0;
      frame_tick_r <= 1'b0;
      frame_cnt_r  <= {CNTW{1'b0}};
    end else begin
      vs_d_r       <= vs;
      vs_vld_r     <= 1'b1;
      frame_tick_r <= vs_vld_r & vs_d_r & ~vs;
      if (frame_tick_r) begin
        frame_cnt_r <= frame_cnt_r + CNTW'(1);
      end else begin
        frame_cnt_r <= frame_cnt_r;
      end
    end
  end

  // decode which channel the config strobes address; out-of-range indices match nothing
  always_comb begin
    wr_sel_s = {CH{1'b0}};
    ab_sel_s = {CH{1'b0}};
    for (int i = 0; i < CH; i++) begin
      if (cfg_ch == CHW'(i)) begin
        wr_sel_s[i] = cfg_we;
        ab_sel_s[i] = cfg_abort;
      end else begin
        wr_sel_s[i] = 1'b0;
        ab_sel_s[i] = 1'b0;
      end
    end
  end

  // per-channel next state: write beats abort beats tick
  always_comb begin
    busy_s = 1'b0;
    for (int i = 0; i < CH; i++) begin
      state_s[i]     = state_r[i];
      start_s[i]     = start_r[i];
      rem_s[i]       = rem_r[i];
      len_s[i]       = len_r[i];
      per_s[i]       = per_r[i];
      mode_s[i]      = mode_r[i];
      start_pls_s[i] = 1'b0;
      stop_pls_s[i]  = 1'b0;
      step_s[i]      = (per_r[i] == {LENW{1'b0}}) ? len_r[i] : per_r[i];
      if (wr_sel_s[i]) begin
        start_s[i]    = cfg_start;
        len_s[i]      = cfg_len;
        per_s[i]      = cfg_period;
        mode_s[i]     = (cfg_mode == 2'd3) ? MODE_SINGLE : cfg_mode;
        rem_s[i]      = {LENW{1'b0}};
        state_s[i]    = ST_ARMED;
        stop_pls_s[i] = (state_r[i] == ST_ACTIVE);
      end else if (ab_sel_s[i]) begin
        state_s[i]    = ST_IDLE;
        stop_pls_s[i] = (state_r[i] == ST_ACTIVE);
      end else if (frame_tick_r) begin
        case (state_r[i])
          ST_ARMED: begin
            if (frame_cnt_r == start_r[i]) begin
              if ((len_r[i] != {LENW{1'b0}}) || (mode_r[i] == MODE_OPEN)) begin
                state_s[i]     = ST_ACTIVE;
                rem_s[i]       = len_r[i];
                start_pls_s[i] = 1'b1;
              end else begin
                state_s[i] = ST_DONE;
              end
            end else begin
              state_s[i] = ST_ARMED;
            end
          end
          ST_ACTIVE: begin
            if (mode_r[i] == MODE_OPEN) begin
              state_s[i] = ST_ACTIVE;
            end else if (rem_r[i] == LENW'(1)) begin
              stop_pls_s[i] = 1'b1;
              rem_s[i]      = {LENW{1'b0}};
              if (mode_r[i] == MODE_PERIODIC) begin
                state_s[i] = ST_ARMED;
                start_s[i] = start_r[i] + CNTW'(step_s[i]);
              end else begin
                state_s[i] = ST_DONE;
              end
            end else begin
              rem_s[i] = rem_r[i] - LENW'(1);
            end
          end
          default: begin
            state_s[i] = state_r[i];
          end
        endcase
      end else begin
        state_s[i] = state_r[i];
      end
      on_s[i] = (state_s[i] == ST_ACTIVE);
      busy_s  = busy_s | (state_s[i] == ST_ARMED) | (state_s[i] == ST_ACTIVE);
    end
  end

  // channel state and field registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) begin
        state_r[i] <= ST_IDLE;
        start_r[i] <= {CNTW{1'b0}};
        rem_r[i]   <= {LENW{1'b0}};
        len_r[i]   <= {LENW{1'b0}};
        per_r[i]   <= {LENW{1'b0}};
        mode_r[i]  <= 2'd0;
      end
    end else begin
      for (int i = 0; i < CH; i++) begin
        state_r[i] <= state_s[i];
        start_r[i] <= start_s[i];
        rem_r[i]   <= rem_s[i];
        len_r[i]   <= len_s[i];
        per_r[i]   <= per_s[i];
        mode_r[i]  <= mode_s[i];
      end
    end
  end

  // output registers, loaded from next-state so pulses align with the transition
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      on_r        <= {CH{1'b0}};
      start_pls_r <= {CH{1'b0}};
      stop_pls_r  <= {CH{1'b0}};
      busy_r      <= 1'b0;
    end else begin
      on_r        <= on_s;
      start_pls_r <= start_pls_s;
      stop_pls_r  <= stop_pls_s;
      busy_r      <= busy_s;
    end
  end

  assign frame_cnt  = frame_cnt_r;
  assign frame_tick = frame_tick_r;
  assign dump_on    = on_r;
  assign dump_start = start_pls_r;
  assign dump_stop  = stop_pls_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_frame_dump_trig.sv
// Scoreboard bench for frame_dump_trig: default-width instance plus a 4-bit counter
// instance for wrap-around; expected post-tick outputs are queued and popped per tick.
module tb_frame_dump_trig;

  typedef struct packed {
    logic [31:0] cnt;
    logic [3:0]  on;
    logic [3:0]  st;
    logic [3:0]  sp;
    logic        busy;
  } obs_t;

  logic        clk;
  logic        rst_n;
  logic        vs;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [31:0] cfg_start;
  logic [15:0] cfg_len;
  logic [15:0] cfg_period;
  logic [1:0]  cfg_mode;
  logic        cfg_abort;

  logic [31:0] frame_cnt1;
  logic        frame_tick1;
  logic [3:0]  dump_on1, dump_start1, dump_stop1;
  logic        busy1;
  logic [3:0]  frame_cnt2;
  logic        frame_tick2;
  logic [3:0]  dump_on2, dump_start2, dump_stop2;
  logic        busy2;

  int   errors = 0;
  int   checks = 0;
  obs_t obs1, obs2, e;
  obs_t exp_q[$];
  logic obs_tick;

  frame_dump_trig #(.CNTW(32), .CH(4), .LENW(16)) dut (
    .clk(clk), .rst_n(rst_n), .vs(vs), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_start(cfg_start), .cfg_len(cfg_len), .cfg_period(cfg_period),
    .cfg_mode(cfg_mode), .cfg_abort(cfg_abort), .frame_cnt(frame_cnt1),
    .frame_tick(frame_tick1), .dump_on(dump_on1), .dump_start(dump_start1),
    .dump_stop(dump_stop1), .busy(busy1)
  );

  frame_dump_trig #(.CNTW(4), .CH(4), .LENW(16)) dut_w (
    .clk(clk), .rst_n(rst_n), .vs(vs), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_start(cfg_start[3:0]), .cfg_len(cfg_len), .cfg_period(cfg_period),
    .cfg_mode(cfg_mode), .cfg_abort(cfg_abort), .frame_cnt(frame_cnt2),
    .frame_tick(frame_tick2), .dump_on(dump_on2), .dump_start(dump_start2),
    .dump_stop(dump_stop2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic obs_t mk(input logic [31:0] c, input logic [3:0] o,
                              input logic [3:0] s, input logic [3:0] p, input logic b);
    mk = {c, o, s, p, b};
  endfunction

  task automatic snap();
    obs1 = {frame_cnt1, dump_on1, dump_start1, dump_stop1, busy1};
    obs2 = {28'd0, frame_cnt2, dump_on2, dump_start2, dump_stop2, busy2};
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; vs = 1'b1; cfg_we = 1'b0; cfg_abort = 1'b0; cfg_ch = 2'd0;
    cfg_start = 32'd0; cfg_len = 16'd0; cfg_period = 16'd0; cfg_mode = 2'd0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic cfg_op(input logic we, input logic ab, input logic [1:0] ch,
                        input logic [31:0] st, input logic [15:0] len,
                        input logic [15:0] per, input logic [1:0] mode);
    @(negedge clk);
    cfg_we = we; cfg_abort = ab; cfg_ch = ch; cfg_start = st;
    cfg_len = len; cfg_period = per; cfg_mode = mode;
    @(posedge clk); #1 snap();
    @(negedge clk);
    cfg_we = 1'b0; cfg_abort = 1'b0;
  endtask

  // one vs falling edge; outputs sampled after the edge where the tick is processed
  task automatic vs_tick();
    @(negedge clk) vs = 1'b0;
    @(posedge clk); #1 obs_tick = frame_tick1;
    @(posedge clk); #1 snap();
    @(negedge clk) vs = 1'b1;
    @(posedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; vs = 1'b0; cfg_we = 1'b0; cfg_abort = 1'b0;
    #1 snap();
    checks++;
    if (obs1 !== mk(32'd0, 4'd0, 4'd0, 4'd0, 1'b0) || frame_tick1 !== 1'b0)
      begin errors++; $display("FAIL reset_hold got %h tick=%b want 0", obs1, frame_tick1); end
    checks++;
    if (obs2 !== mk(32'd0, 4'd0, 4'd0, 4'd0, 1'b0))
      begin errors++; $display("FAIL reset_hold_w got %h want 0", obs2); end
    @(negedge clk) rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (frame_tick1 !== 1'b0 || frame_cnt1 !== 32'd0)
        begin errors++; $display("FAIL vs_low_after_reset cyc=%0d got tick=%b cnt=%0d want 0/0", c, frame_tick1, frame_cnt1); end
    end
    @(negedge clk) vs = 1'b1;
    @(posedge clk);
    vs_tick();
    checks++;
    if (frame_cnt1 !== 32'd1)
      begin errors++; $display("FAIL first_edge got cnt=%0d want 1", frame_cnt1); end
  endtask

  task automatic test_single();
    do_reset();
    exp_q.push_back(mk(32'd0, 4'd0, 4'd0, 4'd0, 1'b1));
    for (int k = 0; k < 8; k++)
      exp_q.push_back(mk(32'(k + 1), (k == 3 || k == 4) ? 4'b0001 : 4'b0000,
                         (k == 3) ? 4'b0001 : 4'b0000, (k == 5) ? 4'b0001 : 4'b0000, k < 5));
    cfg_op(1'b1, 1'b0, 2'd0, 32'd3, 16'd2, 16'd0, 2'd0);
    e = exp_q.pop_front();
    checks++;
    if (obs1 !== e) begin errors++; $display("FAIL single_write got %h want %h", obs1, e); end
    for (int k = 0; k < 8; k++) begin
      vs_tick();
      e = exp_q.pop_front();
      checks++;
      if (obs1 !== e) begin errors++; $display("FAIL single k=%0d got %h want %h", k, obs1, e); end
      checks++;
      if (obs_tick !== 1'b1) begin errors++; $display("FAIL frame_tick k=%0d got %b want 1", k, obs_tick); end
    end
  endtask

  task automatic test_periodic();
    do_reset();
    for (int k = 0; k < 16; k++)
      exp_q.push_back(mk(32'(k + 1), (k % 4 == 2) ? 4'b0010 : 4'b0000,
                         (k % 4 == 2) ? 4'b0010 : 4'b0000, (k % 4 == 3) ? 4'b0010 : 4'b0000, 1'b1));
    cfg_op(1'b1, 1'b0, 2'd1, 32'd2, 16'd1, 16'd4, 2'd1);
    for (int k = 0; k < 16; k++) begin
      vs_tick();
      e = exp_q.pop_front();
      checks++;
      if (obs1 !== e) begin errors++; $display("FAIL periodic k=%0d got %h want %h", k, obs1, e); end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int k = 0; k < 20; k++)
      exp_q.push_back(mk(32'((k + 1) % 16), (k >= 15 && k <= 17) ? 4'b0001 : 4'b0000,
                         (k == 15) ? 4'b0001 : 4'b0000, (k == 18) ? 4'b0001 : 4'b0000, k <= 17));
    cfg_op(1'b1, 1'b0, 2'd0, 32'd15, 16'd3, 16'd0, 2'd0);
    for (int k = 0; k < 20; k++) begin
      vs_tick();
      e = exp_q.pop_front();
      checks++;
      if (obs2 !== e) begin errors++; $display("FAIL wrap k=%0d got %h want %h", k, obs2, e); end
    end
  endtask

  task automatic test_collision();
    do_reset();
    for (int k = 0; k < 4; k++) exp_q.push_back(mk(32'(k + 1), 4'd0, 4'd0, 4'd0, 1'b1));
    exp_q.push_back(mk(32'd5, 4'b0100, 4'b0100, 4'd0, 1'b1));
    exp_q.push_back(mk(32'd6, 4'b0100, 4'd0, 4'd0, 1'b1));
    exp_q.push_back(mk(32'd7, 4'd0, 4'd0, 4'b0100, 1'b1));
    for (int k = 7; k < 10; k++) exp_q.push_back(mk(32'(k + 1), 4'd0, 4'd0, 4'd0, 1'b1));
    exp_q.push_back(mk(32'd11, 4'b0001, 4'b0001, 4'd0, 1'b1));
    exp_q.push_back(mk(32'd12, 4'd0, 4'd0, 4'b0001, 1'b0));
    cfg_op(1'b1, 1'b0, 2'd0, 32'd4, 16'd2, 16'd0, 2'd0);
    cfg_op(1'b1, 1'b0, 2'd2, 32'd4, 16'd2, 16'd0, 2'd0);
    for (int k = 0; k < 12; k++) begin
      if (k == 4) begin
        cfg_ch = 2'd0; cfg_start = 32'd10; cfg_len = 16'd1; cfg_period = 16'd0; cfg_mode = 2'd0;
        @(negedge clk) vs = 1'b0;
        @(posedge clk);
        @(negedge clk) cfg_we = 1'b1;
        @(posedge clk); #1 snap();
        @(negedge clk) begin cfg_we = 1'b0; vs = 1'b1; end
        @(posedge clk);
      end else begin
        vs_tick();
      end
      e = exp_q.pop_front();
      checks++;
      if (obs1 !== e) begin errors++; $display("FAIL collision k=%0d got %h want %h", k, obs1, e); end
    end
  endtask

  task automatic test_abort_reset();
    do_reset();
    exp_q.push_back(mk(32'd0, 4'd0, 4'd0, 4'd0, 1'b1));
    exp_q.push_back(mk(32'd1, 4'd0, 4'd0, 4'd0, 1'b1));
    exp_q.push_back(mk(32'd2, 4'b1000, 4'b1000, 4'd0, 1'b1));
    exp_q.push_back(mk(32'd3, 4'b1000, 4'd0, 4'd0, 1'b1));
    exp_q.push_back(mk(32'd4, 4'b1000, 4'd0, 4'd0, 1'b1));
    exp_q.push_back(mk(32'd4, 4'd0, 4'd0, 4'b1000, 1'b0));
    exp_q.push_back(mk(32'd4, 4'd0, 4'd0, 4'd0, 1'b1));
    exp_q.push_back(mk(32'd5, 4'd0, 4'd0, 4'd0, 1'b1));
    exp_q.push_back(mk(32'd6, 4'd0, 4'd0, 4'd0, 1'b1));
    exp_q.push_back(mk(32'd7, 4'b1000, 4'b1000, 4'd0, 1'b1));
    exp_q.push_back(mk(32'd7, 4'd0, 4'd0, 4'b1000, 1'b1));
    exp_q.push_back(mk(32'd7, 4'd0, 4'd0, 4'd0, 1'b1));
    exp_q.push_back(mk(32'd8, 4'd0, 4'd0, 4'd0, 1'b1));
    exp_q.push_back(mk(32'd9, 4'b0010, 4'b0010, 4'd0, 1'b1));
    exp_q.push_back(mk(32'd0, 4'd0, 4'd0, 4'd0, 1'b0));
    exp_q.push_back(mk(32'd0, 4'd0, 4'd0, 4'd0, 1'b0));
    for (int s = 0; s < 16; s++) begin
      case (s)
        0:  cfg_op(1'b1, 1'b0, 2'd3, 32'd1, 16'd0, 16'd0, 2'd2);
        5:  cfg_op(1'b0, 1'b1, 2'd3, 32'd0, 16'd0, 16'd0, 2'd0);
        6:  cfg_op(1'b1, 1'b1, 2'd3, 32'd6, 16'd0, 16'd0, 2'd2);
        10: cfg_op(1'b1, 1'b0, 2'd3, 32'd20, 16'd1, 16'd0, 2'd0);
        11: cfg_op(1'b1, 1'b0, 2'd1, 32'd8, 16'd5, 16'd0, 2'd3);
        14: begin @(negedge clk) rst_n = 1'b0; #1 snap(); end
        15: begin @(posedge clk); #1 snap(); end
        default: vs_tick();
      endcase
      e = exp_q.pop_front();
      checks++;
      if (obs1 !== e) begin errors++; $display("FAIL abort_reset step=%0d got %h want %h", s, obs1, e); end
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_len_zero();
    do_reset();
    for (int k = 0; k < 8; k++) exp_q.push_back(mk(32'(k + 1), 4'd0, 4'd0, 4'd0, k < 5));
    cfg_op(1'b1, 1'b0, 2'd0, 32'd5, 16'd0, 16'd0, 2'd0);
    for (int k = 0; k < 8; k++) begin
      vs_tick();
      e = exp_q.pop_front();
      checks++;
      if (obs1 !== e) begin errors++; $display("FAIL len_zero k=%0d got %h want %h", k, obs1, e); end
    end
  endtask

  initial begin
    rst_n = 1'b0; vs = 1'b1; cfg_we = 1'b0; cfg_abort = 1'b0; cfg_ch = 2'd0;
    cfg_start = 32'd0; cfg_len = 16'd0; cfg_period = 16'd0; cfg_mode = 2'd0;
    obs_tick = 1'b0;
    repeat (2) @(posedge clk);
    test_reset();
    test_single();
    test_periodic();
    test_wrap();
    test_collision();
    test_abort_reset();
    test_len_zero();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
